cmp_pipe_stage: RTL and testbench

Two-stage pipelined comparator that consumes signed 32-bit operand pairs over a valid/ready handshake and produces registered eq/lt/ltu/zero flags for branch and set-less-than logic. It is the registered front end of the combinational equal block. It adds back-pressure and a split-half compare so the 32-bit compare meets timing. A tag travels with each operand pair for downstream matching.

---
 rtl/cmp_pipe_stage.sv | 86 ++++++++
 tb/tb_cmp_pipe_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe_stage.sv
// cmp_pipe_stage: two-stage split-half signed/unsigned comparator with valid/ready handshake.
// Define CMP_STATS_EN to add a saturating eq_count of equal results delivered.
module cmp_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             zero,
`ifdef CMP_STATS_EN
  output logic [15:0]      eq_count,
`endif
  output logic [TAG_W-1:0] out_tag
);
  localparam int H = WIDTH / 2;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             hi_eq;
    logic             lo_eq;
    logic             hi_lt;
    logic             hi_ltu;
    logic             lo_ltu;
  } s1_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             zero;
  } s2_t;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s2_adv, in_xfer;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;
  always_comb begin
    s1_valid_d = in_xfer | (s1_valid_q & ~s2_adv);
    s2_valid_d = s2_adv | (s2_valid_q & ~out_ready);
    s1_d = in_xfer ? {in_tag, a == '0, a[WIDTH-1:H] == b[WIDTH-1:H], a[H-1:0] == b[H-1:0],
                      $signed(a[WIDTH-1:H]) < $signed(b[WIDTH-1:H]),
                      a[WIDTH-1:H] < b[WIDTH-1:H], a[H-1:0] < b[H-1:0]} : s1_q;
    s2_d = s2_adv ? {s1_q.tag, s1_q.hi_eq & s1_q.lo_eq,
                     s1_q.hi_lt | (s1_q.hi_eq & s1_q.lo_ltu),
                     s1_q.hi_ltu | (s1_q.hi_eq & s1_q.lo_ltu), s1_q.zero} : s2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign eq        = s2_q.eq;
  assign lt        = s2_q.lt;
  assign ltu       = s2_q.ltu;
  assign zero      = s2_q.zero;
  assign out_tag   = s2_q.tag;
`ifdef CMP_STATS_EN
  logic [15:0] eq_count_q, eq_count_d;
  always_comb eq_count_d = (s2_valid_q & out_ready & s2_q.eq & ~&eq_count_q) ? eq_count_q + 16'd1 : eq_count_q;
  always_ff @(posedge clk) begin
    if (rst) eq_count_q <= '0;
    else eq_count_q <= eq_count_d;
  end
  assign eq_count = eq_count_q;
`endif
endmodule

// File: tb/tb_cmp_pipe_stage.sv
// tb_cmp_pipe_stage: scoreboard bench for cmp_pipe_stage; expected flags come from a full-width model.
module tb_cmp_pipe_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, eq, lt, ltu, zero;
  logic [31:0] a, b;
  logic [3:0]  in_tag, out_tag;
`ifdef CMP_STATS_EN
  logic [15:0] eq_count;
`endif
  logic [7:0]  exp_q[$], got_q[$];
  logic [7:0]  g, e, snap;
  logic        in_xfer;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  cmp_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .eq(eq), .lt(lt),
    .ltu(ltu), .zero(zero),
`ifdef CMP_STATS_EN
    .eq_count(eq_count),
`endif
    .out_tag(out_tag)
  );

  // one clock: record transfers seen this cycle, then move to the next falling edge
  task automatic step();
    #1;
    in_xfer = in_valid && in_ready;
    if (rst) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (in_xfer) exp_q.push_back({in_tag, a == b, $signed(a) < $signed(b), a < b, a == 32'd0});
      if (out_valid && out_ready) got_q.push_back({out_tag, eq, lt, ltu, zero});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_tag = '0;
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if ({eq, lt, ltu, zero, out_tag} !== 8'h00) begin n_fail++; $display("FAIL reset_flags got %h exp 00", {eq, lt, ltu, zero, out_tag}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    a = 32'd3; b = 32'd1; in_tag = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got out_valid %b exp 0", out_valid); end
    step();
    #1;
    n_checks++; if ({out_valid, eq, lt, ltu, zero, out_tag} !== {5'b10000, 4'd1}) begin
      n_fail++; $display("FAIL single_flags got %b exp 100000001", {out_valid, eq, lt, ltu, zero, out_tag});
    end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL single_result got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[4] = '{32'd9, 32'd15, 32'd6, 32'd0};
    logic [31:0] tb[4] = '{32'd9, 32'd15, 32'd8, 32'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = ta[i]; b = tb[i]; in_tag = 4'(i); in_valid = 1'b1;
      step();
      n_checks++; if (in_xfer !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d got %b exp 1", i, in_xfer); end
    end
    in_valid = 1'b0;
    step(); step();
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL b2b_rate got %0d results exp 4", got_q.size()); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_result got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    #1;
    snap = {out_tag, eq, lt, ltu, zero};
    n_checks++; if (snap !== {4'd3, 4'b0111}) begin n_fail++; $display("FAIL b2b_last got %h exp 37", snap); end
    step(); step(); step();
    #1;
    n_checks++; if ({out_valid, out_tag, eq, lt, ltu, zero} !== {1'b0, snap}) begin
      n_fail++; $display("FAIL idle_hold got %h exp %h", {out_valid, out_tag, eq, lt, ltu, zero}, {1'b0, snap});
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta[3] = '{32'hFFFFFFFF, 32'h7F000000, 32'h00010000};
    logic [31:0] tb[3] = '{32'd1, 32'd232, 32'h0000FFFF};
    logic [3:0]  want[3] = '{4'b0100, 4'b0000, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; in_tag = 4'(i + 4); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) step();
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL signed_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL signed_model%0d got %h exp %h", i, g, e); end
      n_checks++; if (g[3:0] !== want[i]) begin n_fail++; $display("FAIL signed_flags%0d got %b exp %b", i, g[3:0], want[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] ta[3] = '{32'd10, 32'd20, 32'd30};
    logic [31:0] tb[3] = '{32'd10, 32'd25, 32'd5};
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3); a = ta[idx % 3]; b = tb[idx % 3]; in_tag = 4'(idx);
      step();
      if (in_xfer) idx++;
      #1;
      if (c == 1) snap = {out_tag, eq, lt, ltu, zero};
      if (c >= 2) begin
        n_checks++; if ({out_valid, out_tag, eq, lt, ltu, zero} !== {1'b1, snap}) begin
          n_fail++; $display("FAIL stall_hold%0d got %h exp %h", c, {out_valid, out_tag, eq, lt, ltu, zero}, {1'b1, snap});
        end
      end
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("FAIL stall_accepted got %0d exp 2", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (idx < 3 || got_q.size() < exp_q.size()); k++) begin
      in_valid = (idx < 3); a = ta[idx % 3]; b = tb[idx % 3]; in_tag = 4'(idx);
      step();
      if (in_xfer) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL stall_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e || g[7:4] !== 4'(i)) begin n_fail++; $display("FAIL stall_order%0d got %h exp %h", i, g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 32'd1; b = 32'd1; in_tag = 4'(i + 8); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if ({out_valid, eq, lt, ltu, zero, out_tag} !== 9'h000) begin
      n_fail++; $display("FAIL midreset_out got %h exp 000", {out_valid, eq, lt, ltu, zero, out_tag});
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    repeat (6) step();
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midreset_ghost got %0d results exp 0", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef CMP_STATS_EN
  task automatic test_stats();
    logic [31:0] ta[4] = '{32'd1, 32'd2, 32'd3, 32'd5};
    logic [31:0] tb[4] = '{32'd1, 32'd2, 32'd4, 32'd5};
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = ta[i]; b = tb[i]; in_tag = 4'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    #1;
    n_checks++; if (eq_count !== 16'd3) begin n_fail++; $display("FAIL stats_count got %h exp 0003", eq_count); end
    force dut.eq_count_q = 16'hFFFE;
    step();
    release dut.eq_count_q;
    for (int i = 0; i < 3; i++) begin
      a = 32'd7; b = 32'd7; in_tag = 4'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    #1;
    n_checks++; if (eq_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate got %h exp ffff", eq_count); end
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_signed();
    test_stall();
    test_reset_mid();
`ifdef CMP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
